// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - round-robin arbiter with registered one-hot/indexed grant, hold limit and release gap
module rr_arbiter_8 #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           revoked
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic           r_gnt_valid;
  logic           r_revoked;
  logic [7:0]     r_hold;

  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_idx;
  logic           w_found;
  logic           w_any;
  logic           w_others;
  logic           w_release;
  logic           w_hold_hit;
  logic           w_load;
  logic           w_revoke_go;

  // Search starts just past the current pointer so the last owner is considered last.
  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      w_idx = r_ptr + IDW'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_any      = |req;
  assign w_others   = |(req & ~r_gnt);
  assign w_release  = ~req[r_ptr];
  assign w_hold_hit = (MAX_HOLD != 0) && (r_hold == 8'(MAX_HOLD - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_revoke_go = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_load      = 1'b1;
        end
      end
      S_GRANT: begin
        // Release wins over a coincident timeout so revoked stays low.
        if (w_release) begin
          w_state_nxt = S_GAP;
        end else if (w_hold_hit && w_others) begin
          w_state_nxt = S_GAP;
          w_revoke_go = 1'b1;
        end
      end
      S_GAP: begin
        if (w_any) begin
          w_state_nxt = S_GRANT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= IDW'(N - 1);
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_revoked   <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_revoked <= w_revoke_go;
      if (w_load) begin
        r_ptr       <= w_win;
        r_gnt       <= {{(N-1){1'b0}}, 1'b1} << w_win;
        r_gnt_id    <= w_win;
        r_gnt_valid <= 1'b1;
        r_hold      <= '0;
      end else if (r_state == S_GRANT && w_state_nxt == S_GAP) begin
        r_gnt       <= '0;
        r_gnt_id    <= '0;
        r_gnt_valid <= 1'b0;
      end else if (r_state == S_GRANT && w_others && r_hold != 8'd255) begin
        // Counter only advances while someone else is waiting.
        r_hold <= r_hold + 8'd1;
      end
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign revoked   = r_revoked;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       revoked;

  int total;
  int bad;

  rr_arbiter_8 #(.N(8), .IDW(3), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .revoked   (revoked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    req   = 8'h00;
    #2;

    // T1: reset holds everything low even with all requests up
    rst = 1'b1;
    req = 8'hFF;
    #2;
    chk("t1_gnt", 32'(gnt), 32'h00);
    chk("t1_id", 32'(gnt_id), 32'd0);
    chk("t1_valid", 32'(gnt_valid), 32'd0);
    chk("t1_revoked", 32'(revoked), 32'd0);
    tick();
    tick();
    chk("t1_gnt_clk", 32'(gnt), 32'h00);
    chk("t1_valid_clk", 32'(gnt_valid), 32'd0);
    rst = 1'b0;
    req = 8'h00;
    tick();
    chk("t1_idle", 32'(gnt), 32'h00);

    // T2: single requester, held for 4 grant cycles then released
    do_reset();
    req = 8'h10;
    tick();
    chk("t2_gnt", 32'(gnt), 32'h10);
    chk("t2_id", 32'(gnt_id), 32'd4);
    chk("t2_valid", 32'(gnt_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold", 32'(gnt), 32'h10);
    end
    req = 8'h00;
    tick();
    chk("t2_rel_gnt", 32'(gnt), 32'h00);
    chk("t2_rel_id", 32'(gnt_id), 32'd0);
    chk("t2_rel_revoked", 32'(revoked), 32'd0);
    tick();
    chk("t2_idle_gnt", 32'(gnt), 32'h00);
    chk("t2_idle_valid", 32'(gnt_valid), 32'd0);

    // T3: full rotation 0..7,0 with a gap cycle after each release
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      int k;
      k = i % 8;
      tick();
      chk("t3_gnt", 32'(gnt), 32'(8'h01 << k));
      chk("t3_id", 32'(gnt_id), 32'(k));
      chk("t3_valid", 32'(gnt_valid), 32'd1);
      req = 8'hFF & ~(8'h01 << k);
      tick();
      chk("t3_gap_gnt", 32'(gnt), 32'h00);
      chk("t3_gap_revoked", 32'(revoked), 32'd0);
      req = 8'hFF;
    end

    // T4: timeout revoke after 4 cycles while requester 5 waits
    do_reset();
    req = 8'h24;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_owner2", 32'(gnt), 32'h04);
      chk("t4_owner2_rv", 32'(revoked), 32'd0);
    end
    tick();
    chk("t4_gap_gnt", 32'(gnt), 32'h00);
    chk("t4_gap_revoked", 32'(revoked), 32'd1);
    tick();
    chk("t4_owner5", 32'(gnt), 32'h20);
    chk("t4_owner5_id", 32'(gnt_id), 32'd5);
    chk("t4_rv_pulse", 32'(revoked), 32'd0);
    req = 8'h04;
    tick();
    chk("t4_rel_gnt", 32'(gnt), 32'h00);
    chk("t4_rel_revoked", 32'(revoked), 32'd0);
    tick();
    chk("t4_regrant2", 32'(gnt), 32'h04);
    chk("t4_regrant2_id", 32'(gnt_id), 32'd2);

    // T5: lone owner is never revoked
    do_reset();
    req = 8'h08;
    for (int i = 0; i < 300; i++) begin
      tick();
      chk("t5_gnt", 32'(gnt), 32'h08);
      chk("t5_revoked", 32'(revoked), 32'd0);
    end

    // T6: reset mid-grant, then requester 0 wins first
    do_reset();
    req = 8'h40;
    tick();
    chk("t6_owner6", 32'(gnt), 32'h40);
    req = 8'hC1;
    tick();
    tick();
    chk("t6_ignore_new", 32'(gnt_id), 32'd6);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_gnt", 32'(gnt), 32'h00);
    chk("t6_async_valid", 32'(gnt_valid), 32'd0);
    chk("t6_async_id", 32'(gnt_id), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_first_gnt", 32'(gnt), 32'h01);
    chk("t6_first_id", 32'(gnt_id), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
